// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard controller: multdiv stall FSM, load-use interlock, branch flush
//
// Purpose:
//   Watches the instructions in decode (IR_D) and execute (IR_X) and produces
//   the stall / bubble / flush controls for a five-stage pipeline with a
//   multi-cycle multiply/divide unit.
//
// Ports:
//   clock            rising-edge clock for all state
//   reset            asynchronous active-high reset; all outputs 0 while high
//   IR_D             instruction in decode (F/D latch output)
//   IR_X             instruction in execute (D/X latch output)
//   branch_taken     taken branch/jump resolved in X this cycle
//   md_ready         multdiv result valid
//   md_exception     multdiv exception, meaningful with md_ready
//   ctrl_mult        one-cycle multiply start pulse
//   ctrl_div         one-cycle divide start pulse
//   stall_FD         hold PC and F/D latch
//   stall_DX         hold D/X latch
//   bubble_DX        load nop into D/X
//   bubble_XM        load nop into X/M
//   flush            squash F/D and D/X to nop
//   md_result_valid  X/M captures the multdiv result
//   md_exception_out registered md_exception, valid with md_result_valid
//   md_timeout       high in the DONE cycle of a forced completion
//
// Configuration:
//   MD_TIMEOUT_EN    when defined, BUSY is forced to DONE after MD_TIMEOUT
//                    cycles without md_ready; otherwise BUSY waits forever.

module hazard_controller #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_X,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall_FD,
  output logic        stall_DX,
  output logic        bubble_DX,
  output logic        bubble_XM,
  output logic        flush,
  output logic        md_result_valid,
  output logic        md_exception_out,
  output logic        md_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   exc_q;

  // Instruction field decode
  logic [4:0] op_x, rd_x, alu_x;
  logic [4:0] op_d, rs_d, rt_d;
  logic       x_mul, x_div, x_lw, d_rtype;
  logic       start, load_use;

  assign op_x  = IR_X[31:27];
  assign rd_x  = IR_X[26:22];
  assign alu_x = IR_X[6:2];
  assign op_d  = IR_D[31:27];
  assign rs_d  = IR_D[21:17];
  assign rt_d  = IR_D[16:12];

  assign x_mul   = (op_x == 5'b00000) && (alu_x == 5'b00110);
  assign x_div   = (op_x == 5'b00000) && (alu_x == 5'b00111);
  assign x_lw    = (op_x == 5'b01000);
  assign d_rtype = (op_d == 5'b00000);

  // A taken branch squashes the mul/div in X, so it must not start.
  assign start = (x_mul || x_div) && !branch_taken;

  // Rt is only a source for R-type; a store's data register sits in Rd and
  // is forwarded at M, so it never needs the interlock.
  assign load_use = x_lw && (rd_x != 5'd0) && !branch_taken &&
                    ((rs_d == rd_x) || (d_rtype && (rt_d == rd_x)));

  // Fields the controller never looks at
  logic unused_bits;
  assign unused_bits = ^{IR_X[21:7], IR_X[1:0], IR_D[26:22], IR_D[11:0]};

`ifdef MD_TIMEOUT_EN
  logic [6:0] count;
  logic       timeout_q;
  assign md_timeout = timeout_q;
`else
  logic unused_param;
  assign unused_param = MD_TIMEOUT[0];
  assign md_timeout   = 1'b0;
`endif

  assign md_exception_out = exc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      exc_q <= 1'b0;
`ifdef MD_TIMEOUT_EN
      count     <= 7'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
`ifdef MD_TIMEOUT_EN
            count <= 7'd0;
`endif
          end
        end
        BUSY: begin
`ifdef MD_TIMEOUT_EN
          count <= count + 7'd1;
`endif
          if (md_ready) begin
            state <= DONE;
            exc_q <= md_exception;
          end
`ifdef MD_TIMEOUT_EN
          else if (count == 7'(MD_TIMEOUT - 1)) begin
            state     <= DONE;
            exc_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          exc_q <= 1'b0;
`ifdef MD_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational controls; gated by reset so that a start pattern already
  // present in IR_X cannot leak out while reset is held.
  always_comb begin
    ctrl_mult       = 1'b0;
    ctrl_div        = 1'b0;
    stall_FD        = 1'b0;
    stall_DX        = 1'b0;
    bubble_DX       = 1'b0;
    bubble_XM       = 1'b0;
    flush           = 1'b0;
    md_result_valid = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          flush = branch_taken;
          if (start) begin
            ctrl_mult = x_mul;
            ctrl_div  = x_div;
            stall_FD  = 1'b1;
            stall_DX  = 1'b1;
            bubble_XM = 1'b1;
          end else if (load_use) begin
            stall_FD  = 1'b1;
            bubble_DX = 1'b1;
          end
        end
        BUSY: begin
          stall_FD  = 1'b1;
          stall_DX  = 1'b1;
          bubble_XM = 1'b1;
        end
        DONE: md_result_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller

module tb_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR_D, IR_X;
  logic        branch_taken, md_ready, md_exception;
  logic        ctrl_mult, ctrl_div, stall_FD, stall_DX, bubble_DX, bubble_XM;
  logic        flush, md_result_valid, md_exception_out, md_timeout;

  int vectors = 0;
  int errs    = 0;
  int stall_cnt, mult_cnt, div_cnt, valid_cnt;

  always #5 clock = ~clock;

  hazard_controller #(.MD_TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .IR_D(IR_D), .IR_X(IR_X),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall_FD(stall_FD), .stall_DX(stall_DX),
    .bubble_DX(bubble_DX), .bubble_XM(bubble_XM), .flush(flush),
    .md_result_valid(md_result_valid), .md_exception_out(md_exception_out),
    .md_timeout(md_timeout)
  );

  // Output vector order: ctrl_mult ctrl_div stall_FD stall_DX bubble_DX
  // bubble_XM flush md_result_valid md_exception_out md_timeout
  localparam logic [9:0] ZERO     = 10'b00_0000_0000;
  localparam logic [9:0] ST_MUL   = 10'b10_1101_0000;
  localparam logic [9:0] ST_DIV   = 10'b01_1101_0000;
  localparam logic [9:0] BUSY     = 10'b00_1101_0000;
  localparam logic [9:0] DONE     = 10'b00_0000_0100;
  localparam logic [9:0] DONE_EXC = 10'b00_0000_0110;
  localparam logic [9:0] DONE_TO  = 10'b00_0000_0111;
  localparam logic [9:0] LDUSE    = 10'b00_1010_0000;
  localparam logic [9:0] FLUSH    = 10'b00_0000_1000;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs);
    return {5'b01000, rd, rs, 17'd0};
  endfunction

  logic [31:0] nop, mul, dv, add_rs3, add_rt3, addi_rt3, add_rs0;

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    #1;
    obs = {ctrl_mult, ctrl_div, stall_FD, stall_DX, bubble_DX, bubble_XM,
           flush, md_result_valid, md_exception_out, md_timeout};
    stall_cnt += int'(stall_FD);
    mult_cnt  += int'(ctrl_mult);
    div_cnt   += int'(ctrl_div);
    valid_cnt += int'(md_result_valid);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clr_tally();
    stall_cnt = 0; mult_cnt = 0; div_cnt = 0; valid_cnt = 0;
  endtask

  initial begin
    nop      = 32'd0;
    mul      = rtype(5'd6, 5'd1, 5'd2, 5'b00110);
    dv       = rtype(5'd7, 5'd1, 5'd2, 5'b00111);
    add_rs3  = rtype(5'd4, 5'd3, 5'd5, 5'b00000);
    add_rt3  = rtype(5'd4, 5'd5, 5'd3, 5'b00000);
    addi_rt3 = {5'b00101, 5'd4, 5'd5, 5'd3, 12'd0};
    add_rs0  = rtype(5'd4, 5'd0, 5'd5, 5'b00000);
    clr_tally();

    reset = 1'b1; IR_D = nop; IR_X = nop;
    branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    tick(); tick();

    // Outputs held low in reset even with a mul waiting in X
    IR_X = mul;
    chk("reset_gate", ZERO);
    tick();

    // Multiply, md_ready 17 cycles after the start pulse
    reset = 1'b0;
    clr_tally();
    chk("mul_start", ST_MUL);
    for (int i = 1; i <= 17; i++) begin
      tick();
      md_ready     = (i == 17);
      branch_taken = (i == 5);
      chk("mul_busy", BUSY);
    end
    tick();
    branch_taken = 1'b0;
    chk("mul_done", DONE);
    tick();
    IR_X = nop;
    chk("mul_idle_ready_ignored", ZERO);
    chk_int("mul_stall_len", stall_cnt, 18);
    chk_int("mul_pulses", mult_cnt, 1);
    chk_int("mul_valid_len", valid_cnt, 1);
    tick();
    md_ready = 1'b0;

    // Load-use via Rs: exactly one stall cycle, then the bubble sits in X
    IR_X = lw(5'd3, 5'd1); IR_D = add_rs3;
    chk("lduse_rs", LDUSE);
    tick();
    IR_X = nop;
    chk("lduse_released", ZERO);
    tick();
    IR_X = lw(5'd3, 5'd1); IR_D = add_rt3;
    chk("lduse_rt", LDUSE);
    tick();
    IR_D = addi_rt3;
    chk("lduse_itype_rt", ZERO);
    tick();
    IR_X = lw(5'd0, 5'd1); IR_D = add_rs0;
    chk("lduse_r0", ZERO);
    tick();
    IR_X = lw(5'd9, 5'd1); IR_D = add_rs3;
    chk("lduse_nomatch", ZERO);
    tick();

    // Taken branch: flush wins over load-use and over a mul/div start
    IR_X = lw(5'd3, 5'd1); IR_D = add_rs3; branch_taken = 1'b1;
    chk("branch_lduse", FLUSH);
    tick();
    IR_X = mul; IR_D = nop;
    chk("branch_mul", FLUSH);
    tick();
    IR_X = nop; branch_taken = 1'b0;
    chk("branch_after", ZERO);
    tick();

    // Div then mul back to back; div completes with an exception
    clr_tally();
    IR_X = dv;
    chk("div_start", ST_DIV);
    for (int i = 1; i <= 3; i++) begin
      tick();
      md_ready = (i == 3); md_exception = (i == 3);
      chk("div_busy", BUSY);
    end
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    chk("div_done_exc", DONE_EXC);
    tick();
    IR_X = mul;
    chk("b2b_mul_start", ST_MUL);
    tick();
    md_ready = 1'b1;
    chk("b2b_mul_busy", BUSY);
    tick();
    md_ready = 1'b0;
    chk("b2b_mul_done", DONE);
    tick();
    IR_X = nop;
    chk("b2b_idle", ZERO);
    chk_int("b2b_div_pulses", div_cnt, 1);
    chk_int("b2b_mul_pulses", mult_cnt, 1);
    tick();

    // Reset during BUSY cycle 5, then a fresh start after release
    IR_X = mul;
    chk("rst_mul_start", ST_MUL);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rst_busy", BUSY);
    end
    #2 reset = 1'b1;
    chk("rst_async", ZERO);
    tick();
    chk("rst_held", ZERO);
    tick();
    reset = 1'b0;
    chk("rst_fresh_start", ST_MUL);
    tick();
    md_ready = 1'b1;
    chk("rst_busy_again", BUSY);
    tick();
    md_ready = 1'b0;
    chk("rst_done", DONE);
    tick();
    IR_X = nop;
    chk("rst_idle", ZERO);
    tick();

    // md_ready never arrives
    IR_X = mul;
    chk("to_start", ST_MUL);
`ifdef MD_TIMEOUT_EN
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("to_busy", BUSY);
    end
    tick();
    chk("to_done", DONE_TO);
    tick();
    IR_X = nop;
    chk("to_idle", ZERO);
`else
    for (int i = 1; i <= 70; i++) begin
      tick();
      chk("wait_busy", BUSY);
    end
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    chk("wait_done", DONE);
    tick();
    IR_X = nop;
    chk("wait_idle", ZERO);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
